// File: rtl/mc_defs_pkg.sv
// Shared definitions for the multi-cycle accumulator core: opcodes,
// FSM state encoding, instruction field positions and a counter helper.
package mc_defs;

  // Instruction field positions within the 9-bit instruction word
  localparam int IW     = 9;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 5;
  localparam int X_MSB  = 4;
  localparam int X_LSB  = 1;
  localparam int T_BIT  = 0;

  // Opcodes; every encoding not listed behaves as a no-op
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_LDS = 4'h5;
  localparam logic [3:0] OP_BRC = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;
  localparam logic [3:0] OP_NOP = 4'h8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // 16-bit counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mc_core_top_regfile.sv
// Register file: one write port, async read of r[x] and of the accumulator r0.
// Indices at or above NREG read as zero and drop writes.
module mc_regfile #(
  parameter int W    = 8,
  parameter int NREG = 16
) (
  input  logic         clk,
  input  logic         start_i,
  input  logic         we_i,
  input  logic [3:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [3:0]   raddr_i,
  output logic [W-1:0] rdata_o,
  output logic [W-1:0] r0_o
);

  localparam int AW = $clog2(NREG);

  logic [W-1:0] regs_q [NREG];

  // Clear on start, otherwise write the addressed register when in range
  // NOTE: this array is cleared by the reset because software relies on every
  // register reading zero after start; larger memories are normally left unreset.
  always_ff @(posedge clk) begin
    if (start_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (int'(waddr_i) < NREG)) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = (int'(raddr_i) < NREG) ? regs_q[raddr_i[AW-1:0]] : '0;
  assign r0_o    = regs_q[0];

endmodule

// File: rtl/mc_core_top.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM/HALT sequencer with external
// instruction ROM, handshaked data memory and saturating cycle/instruction counters.
module mc_core_top
  import mc_defs::*;
#(
  parameter int W    = 8,
  parameter int NREG = 16,
  parameter int PCW  = 10
) (
  input  logic           CLK,
  input  logic           start,
  output logic           halt,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [W-1:0]   dmem_addr,
  output logic [W-1:0]   dmem_wdata,
  input  logic [W-1:0]   dmem_rdata,
  input  logic           dmem_ready,
  output logic [15:0]    cycle_ct,
  output logic [15:0]    instr_ct
);

  state_e          state_q;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [IW-1:0]   ir_q;
  logic            z_q, halt_q, req_q, we_q;
  logic [W-1:0]    addr_q, wdata_q;
  logic [15:0]     cyc_q, ins_q;

  logic [3:0]      op, x;
  logic            t;
  logic [W-1:0]    r0, rx, alu_res;
  logic            is_alu, retire;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [W-1:0]    rf_wdata;

  assign op = ir_q[OP_MSB:OP_LSB];
  assign x  = ir_q[X_MSB:X_LSB];
  assign t  = ir_q[T_BIT];

  mc_regfile #(.W(W), .NREG(NREG)) u_rf (
    .clk     (CLK),
    .start_i (start),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .raddr_i (x),
    .rdata_o (rx),
    .r0_o    (r0)
  );

  // ALU, register-file write selection, next PC and retire detection
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res  = '0;
    is_alu   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_wdata = '0;
    pc_d     = pc_q + PCW'(1);
    unique case (op)
      OP_ADD:  begin alu_res = r0 + rx; is_alu = 1'b1; end
      OP_SUB:  begin alu_res = r0 - rx; is_alu = 1'b1; end
      OP_AND:  begin alu_res = r0 & rx; is_alu = 1'b1; end
      OP_XOR:  begin alu_res = r0 ^ rx; is_alu = 1'b1; end
      default: ;
    endcase
    if (op == OP_BRC && z_q) pc_d = t ? pc_q - PCW'(x) : pc_q + PCW'(x);
    if (state_q == ST_EXEC) begin
      if (is_alu) begin
        rf_we    = 1'b1;
        rf_wdata = alu_res;
      end else if (op == OP_MOV) begin
        rf_we    = 1'b1;
        rf_waddr = t ? 4'd0 : x;
        rf_wdata = t ? rx : r0;
      end
    end else if (state_q == ST_MEM && dmem_ready && !we_q) begin
      rf_we    = 1'b1;
      rf_waddr = x;
      rf_wdata = dmem_rdata;
    end
    retire = (state_q == ST_EXEC && op != OP_LDS) || (state_q == ST_MEM && dmem_ready);
  end

  // Sequencer: state, PC, IR, Z flag, memory request outputs and counters
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (start) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      halt_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      if (state_q != ST_HALT) cyc_q <= sat_inc(cyc_q);
      if (retire)             ins_q <= sat_inc(ins_q);
      unique case (state_q)
        ST_FETCH: begin
          ir_q    <= imem_data;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op == OP_LDS) begin
            state_q <= ST_MEM;
            req_q   <= 1'b1;
            we_q    <= t;
            addr_q  <= r0;
            wdata_q <= rx;
          end else if (op == OP_HLT) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
          end else begin
            if (is_alu) z_q <= (alu_res == '0);
            pc_q    <= pc_d;
            state_q <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            req_q   <= 1'b0;
            pc_q    <= pc_q + PCW'(1);
            state_q <= ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign halt       = halt_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign cycle_ct   = cyc_q;
  assign instr_ct   = ins_q;

endmodule

// File: tb/tb_mc_core_top.sv
// Directed bench for mc_core_top: default-parameter core plus an NREG=4 core.
module tb_mc_core_top;
  import mc_defs::*;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Main DUT (W=8, NREG=16, PCW=10)
  logic        start = 1'b1;
  logic        halt;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_data;
  logic        dmem_req, dmem_we;
  logic [7:0]  dmem_addr, dmem_wdata;
  logic [7:0]  dmem_rdata = 8'h00;
  logic        dmem_ready = 1'b1;
  logic [15:0] cycle_ct, instr_ct;
  logic [8:0]  rom [1024];
  assign imem_data = rom[imem_addr];

  mc_core_top #(.W(8), .NREG(16), .PCW(10)) dut (
    .CLK(CLK), .start(start), .halt(halt),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .cycle_ct(cycle_ct), .instr_ct(instr_ct)
  );

  // Small-register-file DUT (NREG=4)
  logic        start4 = 1'b1;
  logic        halt4;
  logic [9:0]  imem_addr4;
  logic [8:0]  imem_data4;
  logic        dmem_req4, dmem_we4;
  logic [7:0]  dmem_addr4, dmem_wdata4;
  logic [7:0]  dmem_rdata4 = 8'h00;
  logic        dmem_ready4 = 1'b1;
  logic [15:0] cycle_ct4, instr_ct4;
  logic [8:0]  rom4 [1024];
  assign imem_data4 = rom4[imem_addr4];

  mc_core_top #(.W(8), .NREG(4), .PCW(10)) dut4 (
    .CLK(CLK), .start(start4), .halt(halt4),
    .imem_addr(imem_addr4), .imem_data(imem_data4),
    .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_addr(dmem_addr4),
    .dmem_wdata(dmem_wdata4), .dmem_rdata(dmem_rdata4), .dmem_ready(dmem_ready4),
    .cycle_ct(cycle_ct4), .instr_ct(instr_ct4)
  );

  function automatic logic [8:0] enc(input logic [3:0] op, input logic [3:0] x, input logic t);
    return {op, x, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) begin
      rom[i]  = enc(OP_NOP, 4'd0, 1'b0);
      rom4[i] = enc(OP_NOP, 4'd0, 1'b0);
    end
  endtask

  task automatic do_reset();
    start = 1'b1;
    run(1);
    start = 1'b0;
  endtask

  initial begin
    clear_rom();
    run(2);

    // 1: MOV T1 x0; ADD x0; HLT
    rom[0] = enc(OP_MOV, 4'd0, 1'b1);
    rom[1] = enc(OP_ADD, 4'd0, 1'b0);
    rom[2] = enc(OP_HLT, 4'd0, 1'b0);
    do_reset();
    check("rst_halt", halt, 0);
    check("rst_pc", imem_addr, 0);
    check("rst_req", dmem_req, 0);
    check("rst_cyc", cycle_ct, 0);
    check("rst_ins", instr_ct, 0);
    run(5);
    check("t1_not_yet_halt", halt, 0);
    run(1);
    check("t1_halt", halt, 1);
    check("t1_instr", instr_ct, 3);
    check("t1_cycle", cycle_ct, 6);
    check("t1_pc_hold", imem_addr, 2);
    run(3);
    check("t1_cycle_frozen", cycle_ct, 6);
    check("t1_halt_sticky", halt, 1);

    // 2: ALU behaviour and Z flag via branches
    clear_rom();
    rom[0] = enc(OP_LDS, 4'd1, 1'b0);
    rom[1] = enc(OP_LDS, 4'd0, 1'b0);
    rom[2] = enc(OP_ADD, 4'd1, 1'b0);
    rom[3] = enc(OP_LDS, 4'd0, 1'b1);
    rom[4] = enc(OP_BRC, 4'd2, 1'b0);
    rom[5] = enc(OP_SUB, 4'd0, 1'b0);
    rom[6] = enc(OP_BRC, 4'd2, 1'b0);
    rom[8] = enc(OP_LDS, 4'd0, 1'b1);
    rom[9] = enc(OP_HLT, 4'd0, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 8'h20;
    do_reset();
    run(2);
    check("t2_ld_req", dmem_req, 1);
    check("t2_ld_we", dmem_we, 0);
    check("t2_ld_addr", dmem_addr, 8'h00);
    run(1);
    check("t2_ld_pc", imem_addr, 1);
    check("t2_ld_retire", instr_ct, 1);
    dmem_rdata = 8'hF0;
    run(3);
    check("t2_pc2", imem_addr, 2);
    run(2);
    check("t2_add_pc", imem_addr, 3);
    run(2);
    check("t2_st_we", dmem_we, 1);
    check("t2_add_r0", dmem_addr, 8'h10);
    check("t2_add_wdata", dmem_wdata, 8'h10);
    run(1);
    run(2);
    check("t2_brc_z0", imem_addr, 5);
    run(2);
    check("t2_sub_pc", imem_addr, 6);
    run(2);
    check("t2_brc_z1", imem_addr, 8);
    run(2);
    check("t2_sub_r0", dmem_addr, 8'h00);
    check("t2_sub_wdata", dmem_wdata, 8'h00);
    run(1);
    run(2);
    check("t2_halt", halt, 1);
    check("t2_instr", instr_ct, 9);
    check("t2_cycle", cycle_ct, 22);

    // 3: load stalled by three not-ready cycles
    clear_rom();
    rom[0] = enc(OP_LDS, 4'd0, 1'b0);
    rom[1] = enc(OP_LDS, 4'd2, 1'b0);
    rom[2] = enc(OP_LDS, 4'd2, 1'b1);
    rom[3] = enc(OP_HLT, 4'd0, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 8'h05;
    do_reset();
    run(3);
    check("t3_pc1", imem_addr, 1);
    dmem_ready = 1'b0;
    dmem_rdata = 8'h33;
    run(2);
    check("t3_req_c1", dmem_req, 1);
    check("t3_addr_c1", dmem_addr, 8'h05);
    for (int k = 2; k <= 4; k++) begin
      run(1);
      check($sformatf("t3_req_c%0d", k), dmem_req, 1);
      check($sformatf("t3_addr_c%0d", k), dmem_addr, 8'h05);
    end
    check("t3_pc_stall", imem_addr, 1);
    check("t3_instr_stall", instr_ct, 1);
    dmem_ready = 1'b1;
    dmem_rdata = 8'hA7;
    run(1);
    check("t3_req_drop", dmem_req, 0);
    check("t3_pc2", imem_addr, 2);
    check("t3_instr", instr_ct, 2);
    run(2);
    check("t3_st_addr", dmem_addr, 8'h05);
    check("t3_r2", dmem_wdata, 8'hA7);
    run(1);
    check("t3_pc3", imem_addr, 3);

    // 4: branches, including wrap in both directions
    clear_rom();
    rom[0]    = enc(OP_SUB, 4'd0, 1'b0);
    rom[1]    = enc(OP_BRC, 4'd9, 1'b0);
    rom[10]   = enc(OP_BRC, 4'd3, 1'b1);
    rom[7]    = enc(OP_LDS, 4'd1, 1'b0);
    rom[8]    = enc(OP_ADD, 4'd1, 1'b0);
    rom[9]    = enc(OP_BRC, 4'd5, 1'b1);
    rom[11]   = enc(OP_SUB, 4'd0, 1'b0);
    rom[12]   = enc(OP_BRC, 4'd13, 1'b1);
    rom[1023] = enc(OP_BRC, 4'd1, 1'b0);
    dmem_ready = 1'b1;
    dmem_rdata = 8'h01;
    do_reset();
    run(2);
    check("t4_pc1", imem_addr, 1);
    run(2);
    check("t4_fwd", imem_addr, 10);
    run(2);
    check("t4_back", imem_addr, 7);
    run(3);
    run(2);
    check("t4_pc9", imem_addr, 9);
    run(2);
    check("t4_nt_back", imem_addr, 10);
    run(2);
    check("t4_nt_z0", imem_addr, 11);
    run(2);
    run(2);
    check("t4_wrap_down", imem_addr, 1023);
    run(2);
    check("t4_wrap_up", imem_addr, 0);

    // 5: start during an outstanding access
    clear_rom();
    rom[0] = enc(OP_LDS, 4'd0, 1'b0);
    rom[1] = enc(OP_LDS, 4'd0, 1'b1);
    dmem_ready = 1'b1;
    dmem_rdata = 8'h55;
    do_reset();
    run(3);
    dmem_ready = 1'b0;
    run(2);
    check("t5_req", dmem_req, 1);
    check("t5_addr", dmem_addr, 8'h55);
    start = 1'b1;
    run(1);
    start = 1'b0;
    check("t5_req_drop", dmem_req, 0);
    check("t5_pc0", imem_addr, 0);
    check("t5_instr0", instr_ct, 0);
    check("t5_cycle0", cycle_ct, 0);
    dmem_ready = 1'b1;
    dmem_rdata = 8'h66;
    run(1);
    check("t5_late_ready_instr", instr_ct, 0);
    check("t5_late_ready_req", dmem_req, 0);
    run(1);
    check("t5_req2", dmem_req, 1);
    check("t5_regs_clr", dmem_addr, 8'h00);
    run(1);
    check("t5_pc1", imem_addr, 1);
    check("t5_instr1", instr_ct, 1);

    // 6: NREG=4, out-of-range register index
    rom4[0] = enc(OP_LDS, 4'd0, 1'b0);
    rom4[1] = enc(OP_MOV, 4'd7, 1'b0);
    rom4[2] = enc(OP_LDS, 4'd0, 1'b1);
    rom4[3] = enc(OP_MOV, 4'd7, 1'b1);
    rom4[4] = enc(OP_LDS, 4'd3, 1'b1);
    rom4[5] = enc(OP_HLT, 4'd0, 1'b0);
    dmem_ready4 = 1'b1;
    dmem_rdata4 = 8'h3C;
    start4 = 1'b1;
    run(1);
    start4 = 1'b0;
    run(3);
    check("t6_pc1", imem_addr4, 1);
    run(2);
    check("t6_mov_t0_pc", imem_addr4, 2);
    run(2);
    check("t6_r0_kept", dmem_addr4, 8'h3C);
    run(1);
    run(2);
    check("t6_mov_t1_pc", imem_addr4, 4);
    run(2);
    check("t6_r0_zero", dmem_addr4, 8'h00);
    check("t6_r3_untouched", dmem_wdata4, 8'h00);
    run(1);
    run(2);
    check("t6_halt", halt4, 1);
    check("t6_instr", instr_ct4, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
